// File: rtl/conv_seq_if.sv
// Column-stream, Conv-drive and result handshake bundle for conv_seq_ctrl.
//   slave  : the sequencer side (consumes columns and result-ready, drives Conv and results)
//   master : the environment side (upstream source, Conv, downstream sink)
`timescale 1ns/1ps
interface conv_seq_if #(
  parameter int unsigned BIT_LEN = 8,
  parameter int unsigned CNT_LEN = 10
);
  logic [3*BIT_LEN-1:0] i_col_data;
  logic                 i_col_valid;
  logic                 o_col_ready;
  logic [BIT_LEN-1:0]   o_dato0;
  logic [BIT_LEN-1:0]   o_dato1;
  logic [BIT_LEN-1:0]   o_dato2;
  logic                 o_selecK_I;
  logic                 o_conv_valid;
  logic                 i_res_ready;
  logic                 o_res_valid;
  logic [CNT_LEN-1:0]   o_res_idx;

  modport slave (
    input  i_col_data, i_col_valid, i_res_ready,
    output o_col_ready, o_dato0, o_dato1, o_dato2, o_selecK_I, o_conv_valid,
           o_res_valid, o_res_idx
  );

  modport master (
    output i_col_data, i_col_valid, i_res_ready,
    input  o_col_ready, o_dato0, o_dato1, o_dato2, o_selecK_I, o_conv_valid,
           o_res_valid, o_res_idx
  );
endinterface

// File: rtl/conv_seq_ctrl.sv
// Sequencer in front of the 3x3 Conv datapath: optional kernel load, W image
// columns, one zero flush column, with per-result valid/ready backpressure.
// Ports:
//   CLK100MHZ, i_reset       clock, synchronous active-high reset
//   i_start, i_load_kernel,  frame start (IDLE only), kernel-load select,
//   i_num_cols               image width W (must be >= M_LEN)
//   bus (conv_seq_if.slave)  column stream in, Conv drive out, result valid/idx out
//   o_busy, o_done, o_err    not-idle, frame-end pulse, bad-width pulse
`timescale 1ns/1ps
module conv_seq_ctrl #(
  parameter int unsigned BIT_LEN = 8,
  parameter int unsigned M_LEN   = 3,
  parameter int unsigned CNT_LEN = 10
) (
  input  logic               CLK100MHZ,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_load_kernel,
  input  logic [CNT_LEN-1:0] i_num_cols,
  conv_seq_if.slave          bus,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  localparam logic [CNT_LEN-1:0] M_CNT = CNT_LEN'(M_LEN);
  localparam logic [CNT_LEN-1:0] ONE   = CNT_LEN'(1);

  typedef enum logic [2:0] {IDLE, LOAD_K, IMG, DRAIN, WAIT_OUT} state_t;

  state_t             state, state_next;
  logic [CNT_LEN-1:0] num_cols;
  logic [CNT_LEN-1:0] cnt;
  logic               res_valid;
  logic [CNT_LEN-1:0] res_idx;
  logic               done;
  logic               err;

  logic               col_ready_c;
  logic               push_c;
  logic               sel_c;
  logic [BIT_LEN-1:0] d0_c, d1_c, d2_c;
  logic               res_take_c;

  assign res_take_c = res_valid & bus.i_res_ready;

  // State register
  always_ff @(posedge CLK100MHZ) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (i_start && (i_num_cols >= M_CNT))
                  state_next = i_load_kernel ? LOAD_K : IMG;
      LOAD_K:   if (push_c && (cnt == M_CNT - ONE)) state_next = IMG;
      IMG:      if (push_c && (cnt == num_cols - ONE)) state_next = DRAIN;
      DRAIN:    if (push_c) state_next = WAIT_OUT;
      WAIT_OUT: if (res_take_c) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Conv-side and handshake outputs
  always_comb begin
    col_ready_c = 1'b0;
    push_c      = 1'b0;
    sel_c       = 1'b1;
    d0_c        = '0;
    d1_c        = '0;
    d2_c        = '0;
    case (state)
      LOAD_K: begin
        col_ready_c = 1'b1;
        sel_c       = 1'b0;
        push_c      = bus.i_col_valid;
        d0_c        = bus.i_col_data[BIT_LEN-1:0];
        d1_c        = bus.i_col_data[2*BIT_LEN-1:BIT_LEN];
        d2_c        = bus.i_col_data[3*BIT_LEN-1:2*BIT_LEN];
      end
      IMG: begin
        // A held result would be overwritten by the next image push.
        col_ready_c = !res_valid | bus.i_res_ready;
        push_c      = bus.i_col_valid & col_ready_c;
        d0_c        = bus.i_col_data[BIT_LEN-1:0];
        d1_c        = bus.i_col_data[2*BIT_LEN-1:BIT_LEN];
        d2_c        = bus.i_col_data[3*BIT_LEN-1:2*BIT_LEN];
      end
      DRAIN:   push_c = !res_valid | bus.i_res_ready;
      default: ;
    endcase
  end

  assign bus.o_col_ready  = col_ready_c;
  assign bus.o_conv_valid = push_c;
  assign bus.o_selecK_I   = sel_c;
  assign bus.o_dato0      = d0_c;
  assign bus.o_dato1      = d1_c;
  assign bus.o_dato2      = d2_c;
  assign bus.o_res_valid  = res_valid;
  assign bus.o_res_idx    = res_idx;
  assign o_busy           = (state != IDLE);
  assign o_done           = done;
  assign o_err            = err;

  // Counters, result flag/index, status pulses
  always_ff @(posedge CLK100MHZ) begin
    if (i_reset) begin
      num_cols  <= '0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_idx   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      // A push in the same cycle below re-sets the flag.
      if (res_take_c) res_valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (i_start) begin
            if (i_num_cols < M_CNT) err <= 1'b1;
            else                    num_cols <= i_num_cols;
          end
        end
        LOAD_K: if (push_c) cnt <= (cnt == M_CNT - ONE) ? '0 : cnt + ONE;
        IMG: if (push_c) begin
          cnt <= (cnt == num_cols - ONE) ? '0 : cnt + ONE;
          // Conv latches window p-M_LEN on the edge that accepts column p.
          if (cnt >= M_CNT) begin
            res_valid <= 1'b1;
            res_idx   <= cnt - M_CNT;
          end
        end
        DRAIN: if (push_c) begin
          res_valid <= 1'b1;
          res_idx   <= num_cols - M_CNT;
        end
        WAIT_OUT: if (res_take_c) done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
`timescale 1ns/1ps
module tb_conv_seq_ctrl;
  localparam int unsigned BIT_LEN = 8;
  localparam int unsigned M_LEN   = 3;
  localparam int unsigned CNT_LEN = 10;

  logic CLK100MHZ = 1'b0;
  always #5 CLK100MHZ = ~CLK100MHZ;

  logic               i_reset, i_start, i_load_kernel;
  logic [CNT_LEN-1:0] i_num_cols;
  logic               o_busy, o_done, o_err;

  conv_seq_if #(.BIT_LEN(BIT_LEN), .CNT_LEN(CNT_LEN)) bus ();

  conv_seq_ctrl #(.BIT_LEN(BIT_LEN), .M_LEN(M_LEN), .CNT_LEN(CNT_LEN)) dut (
    .CLK100MHZ     (CLK100MHZ),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_load_kernel (i_load_kernel),
    .i_num_cols    (i_num_cols),
    .bus           (bus.slave),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_err         (o_err)
  );

  int checks = 0;
  int failures = 0;

  // Upstream source: kernel columns while the sequencer is loading, image otherwise
  logic [23:0] kern_col, img_col;
  assign bus.i_col_data = bus.o_selecK_I ? img_col : kern_col;

  // Reference Conv: kernel shift on selecK_I=0, window output latched on each image push
  logic [7:0]  kw [9];
  logic [7:0]  iw [9];
  logic [19:0] conv_sum, conv_data;
  always_comb begin
    conv_sum = '0;
    for (int i = 0; i < 9; i++) conv_sum = conv_sum + 20'(kw[i]) * 20'(iw[i]);
  end
  always @(posedge CLK100MHZ) begin
    if (i_reset) begin
      for (int i = 0; i < 9; i++) begin kw[i] <= '0; iw[i] <= '0; end
      conv_data <= '0;
    end else if (bus.o_conv_valid) begin
      if (!bus.o_selecK_I) begin
        for (int i = 0; i < 6; i++) kw[i] <= kw[i+3];
        kw[6] <= bus.o_dato0; kw[7] <= bus.o_dato1; kw[8] <= bus.o_dato2;
      end else begin
        conv_data <= conv_sum;
        for (int i = 0; i < 6; i++) iw[i] <= iw[i+3];
        iw[6] <= bus.o_dato0; iw[7] <= bus.o_dato1; iw[8] <= bus.o_dato2;
      end
    end
  end

  // Event monitor
  int push_cnt = 0, kpush_cnt = 0, done_cnt = 0, err_cnt = 0;
  int idx_q[$];
  int dat_q[$];
  always @(posedge CLK100MHZ) begin
    if (!i_reset) begin
      if (bus.o_conv_valid) push_cnt++;
      if (bus.o_conv_valid && !bus.o_selecK_I) kpush_cnt++;
      if (bus.o_res_valid && bus.i_res_ready) begin
        idx_q.push_back(int'(bus.o_res_idx));
        dat_q.push_back(int'(conv_data));
      end
      if (o_done) done_cnt++;
      if (o_err) err_cnt++;
    end
  end

  task automatic tick();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic start_frame(input logic ld, input int w);
    i_load_kernel = ld;
    i_num_cols    = CNT_LEN'(w);
    i_start       = 1'b1;
    tick();
    i_start       = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (o_done) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    tick(); tick();
    checks++; if (bus.o_res_valid !== 1'b0) begin failures++; $display("FAIL rst_res_valid got=%b exp=0", bus.o_res_valid); end
    checks++; if (bus.o_res_idx !== '0) begin failures++; $display("FAIL rst_res_idx got=%0d exp=0", bus.o_res_idx); end
    checks++; if (bus.o_col_ready !== 1'b0) begin failures++; $display("FAIL rst_col_ready got=%b exp=0", bus.o_col_ready); end
    checks++; if (bus.o_conv_valid !== 1'b0) begin failures++; $display("FAIL rst_conv_valid got=%b exp=0", bus.o_conv_valid); end
    checks++; if (bus.o_selecK_I !== 1'b1) begin failures++; $display("FAIL rst_selecK got=%b exp=1", bus.o_selecK_I); end
    checks++; if (bus.o_dato0 !== '0 || bus.o_dato1 !== '0 || bus.o_dato2 !== '0) begin failures++; $display("FAIL rst_dato got=%h/%h/%h exp=0", bus.o_dato0, bus.o_dato1, bus.o_dato2); end
    checks++; if (o_busy !== 1'b0 || o_done !== 1'b0 || o_err !== 1'b0) begin failures++; $display("FAIL rst_status got=busy%b done%b err%b exp=000", o_busy, o_done, o_err); end
    i_reset = 1'b0;
    tick();
  endtask

  task automatic test_kernel_frame();
    int pb = push_cnt, kb = kpush_cnt, db = done_cnt, qb = idx_q.size();
    bit ok;
    bus.i_res_ready = 1'b1; bus.i_col_valid = 1'b1;
    start_frame(1'b1, 5);
    wait_done(60, ok);
    tick();
    checks++; if (!ok) begin failures++; $display("FAIL kf_timeout got=no_done exp=done"); end
    checks++; if (push_cnt - pb != 9) begin failures++; $display("FAIL kf_pushes got=%0d exp=9", push_cnt - pb); end
    checks++; if (kpush_cnt - kb != 3) begin failures++; $display("FAIL kf_kpushes got=%0d exp=3", kpush_cnt - kb); end
    checks++; if (done_cnt - db != 1) begin failures++; $display("FAIL kf_done got=%0d exp=1", done_cnt - db); end
    checks++; if (idx_q.size() - qb != 3) begin failures++; $display("FAIL kf_results got=%0d exp=3", idx_q.size() - qb); end
    for (int k = 0; k < 3 && qb + k < idx_q.size(); k++) begin
      checks++; if (idx_q[qb+k] != k) begin failures++; $display("FAIL kf_idx%0d got=%0d exp=%0d", k, idx_q[qb+k], k); end
      checks++; if (dat_q[qb+k] != 18) begin failures++; $display("FAIL kf_data%0d got=%0d exp=18", k, dat_q[qb+k]); end
    end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL kf_busy_end got=%b exp=0", o_busy); end
  endtask

  task automatic test_backpressure();
    int qb = idx_q.size(), pb = push_cnt;
    bit ok, seen;
    bus.i_res_ready = 1'b1; bus.i_col_valid = 1'b1;
    start_frame(1'b0, 5);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.o_res_valid) begin seen = 1'b1; break; end
      tick();
    end
    checks++; if (!seen) begin failures++; $display("FAIL bp_first_result got=none exp=valid"); end
    bus.i_res_ready = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      checks++; if (bus.o_col_ready !== 1'b0) begin failures++; $display("FAIL bp_col_ready c%0d got=%b exp=0", c, bus.o_col_ready); end
      checks++; if (bus.o_conv_valid !== 1'b0) begin failures++; $display("FAIL bp_conv_valid c%0d got=%b exp=0", c, bus.o_conv_valid); end
      checks++; if (bus.o_res_valid !== 1'b1 || bus.o_res_idx !== '0) begin failures++; $display("FAIL bp_hold c%0d got=v%b i%0d exp=v1 i0", c, bus.o_res_valid, bus.o_res_idx); end
      checks++; if (conv_data !== 20'd18) begin failures++; $display("FAIL bp_conv_data c%0d got=%0d exp=18", c, conv_data); end
      tick();
    end
    checks++; if (push_cnt - pb != 4) begin failures++; $display("FAIL bp_push_during_hold got=%0d exp=4", push_cnt - pb); end
    bus.i_res_ready = 1'b1;
    wait_done(40, ok);
    tick();
    checks++; if (!ok) begin failures++; $display("FAIL bp_timeout got=no_done exp=done"); end
    checks++; if (idx_q.size() - qb != 3) begin failures++; $display("FAIL bp_results got=%0d exp=3", idx_q.size() - qb); end
    for (int k = 0; k < 3 && qb + k < idx_q.size(); k++) begin
      checks++; if (idx_q[qb+k] != k || dat_q[qb+k] != 18) begin failures++; $display("FAIL bp_res%0d got=i%0d d%0d exp=i%0d d18", k, idx_q[qb+k], dat_q[qb+k], k); end
    end
  endtask

  task automatic test_err_then_short();
    int pb = push_cnt, kb = kpush_cnt, eb = err_cnt, qb;
    bit ok;
    bus.i_res_ready = 1'b1; bus.i_col_valid = 1'b1;
    start_frame(1'b1, 2);
    checks++; if (o_err !== 1'b1 || o_busy !== 1'b0) begin failures++; $display("FAIL err_pulse got=err%b busy%b exp=err1 busy0", o_err, o_busy); end
    tick();
    checks++; if (o_err !== 1'b0 || o_busy !== 1'b0) begin failures++; $display("FAIL err_clear got=err%b busy%b exp=err0 busy0", o_err, o_busy); end
    checks++; if (push_cnt - pb != 0) begin failures++; $display("FAIL err_pushes got=%0d exp=0", push_cnt - pb); end
    qb = idx_q.size();
    start_frame(1'b0, 3);
    wait_done(30, ok);
    tick();
    checks++; if (!ok) begin failures++; $display("FAIL w3_timeout got=no_done exp=done"); end
    checks++; if (push_cnt - pb != 4 || kpush_cnt - kb != 0) begin failures++; $display("FAIL w3_pushes got=%0d/k%0d exp=4/k0", push_cnt - pb, kpush_cnt - kb); end
    checks++; if (idx_q.size() - qb != 1) begin failures++; $display("FAIL w3_results got=%0d exp=1", idx_q.size() - qb); end
    else begin
      checks++; if (idx_q[qb] != 0 || dat_q[qb] != 18) begin failures++; $display("FAIL w3_res got=i%0d d%0d exp=i0 d18", idx_q[qb], dat_q[qb]); end
    end
    checks++; if (err_cnt - eb != 1) begin failures++; $display("FAIL err_count got=%0d exp=1", err_cnt - eb); end
  endtask

  task automatic test_toggle_valid();
    int pb = push_cnt, qb = idx_q.size();
    bit ok = 1'b0;
    bus.i_res_ready = 1'b1; bus.i_col_valid = 1'b0;
    start_frame(1'b0, 6);
    for (int i = 0; i < 100; i++) begin
      if (o_done) begin ok = 1'b1; break; end
      bus.i_col_valid = ~bus.i_col_valid;
      tick();
    end
    bus.i_col_valid = 1'b1;
    tick();
    checks++; if (!ok) begin failures++; $display("FAIL tg_timeout got=no_done exp=done"); end
    checks++; if (push_cnt - pb != 7) begin failures++; $display("FAIL tg_pushes got=%0d exp=7", push_cnt - pb); end
    checks++; if (idx_q.size() - qb != 4) begin failures++; $display("FAIL tg_results got=%0d exp=4", idx_q.size() - qb); end
    for (int k = 0; k < 4 && qb + k < idx_q.size(); k++) begin
      checks++; if (idx_q[qb+k] != k) begin failures++; $display("FAIL tg_idx%0d got=%0d exp=%0d", k, idx_q[qb+k], k); end
    end
  endtask

  task automatic test_reset_mid();
    int pb, qb, eb, db;
    bit ok;
    bus.i_res_ready = 1'b1; bus.i_col_valid = 1'b1;
    start_frame(1'b0, 5);
    tick(); tick();
    i_reset = 1'b1;
    tick();
    checks++; if (o_busy !== 1'b0 || bus.o_res_valid !== 1'b0 || bus.o_res_idx !== '0) begin failures++; $display("FAIL rm_state got=busy%b v%b i%0d exp=0", o_busy, bus.o_res_valid, bus.o_res_idx); end
    checks++; if (bus.o_col_ready !== 1'b0 || bus.o_conv_valid !== 1'b0 || bus.o_dato0 !== '0) begin failures++; $display("FAIL rm_outs got=r%b c%b d%h exp=0", bus.o_col_ready, bus.o_conv_valid, bus.o_dato0); end
    i_reset = 1'b0;
    tick();
    pb = push_cnt; qb = idx_q.size(); eb = err_cnt; db = done_cnt;
    start_frame(1'b1, 4);
    i_num_cols = CNT_LEN'(2); i_start = 1'b1;
    tick(); tick(); tick();
    i_start = 1'b0;
    wait_done(40, ok);
    tick();
    checks++; if (!ok) begin failures++; $display("FAIL rm_timeout got=no_done exp=done"); end
    checks++; if (push_cnt - pb != 8 || done_cnt - db != 1) begin failures++; $display("FAIL rm_pushes got=%0d/done%0d exp=8/done1", push_cnt - pb, done_cnt - db); end
    checks++; if (err_cnt - eb != 0) begin failures++; $display("FAIL rm_busy_start got=err%0d exp=err0", err_cnt - eb); end
    checks++; if (idx_q.size() - qb != 2) begin failures++; $display("FAIL rm_results got=%0d exp=2", idx_q.size() - qb); end
    for (int k = 0; k < 2 && qb + k < idx_q.size(); k++) begin
      checks++; if (idx_q[qb+k] != k || dat_q[qb+k] != 18) begin failures++; $display("FAIL rm_res%0d got=i%0d d%0d exp=i%0d d18", k, idx_q[qb+k], dat_q[qb+k], k); end
    end
  endtask

  task automatic test_max_width();
    int qb = idx_q.size(), bad = 0;
    bit ok;
    bus.i_res_ready = 1'b1; bus.i_col_valid = 1'b1;
    start_frame(1'b0, 1023);
    wait_done(1100, ok);
    tick();
    checks++; if (!ok) begin failures++; $display("FAIL mw_timeout got=no_done exp=done"); end
    checks++; if (idx_q.size() - qb != 1021) begin failures++; $display("FAIL mw_results got=%0d exp=1021", idx_q.size() - qb); end
    for (int k = 0; qb + k < idx_q.size(); k++) if (idx_q[qb+k] != k) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL mw_order got=%0d_bad exp=0", bad); end
    checks++; if (idx_q.size() > 0 && idx_q[idx_q.size()-1] != 1020) begin failures++; $display("FAIL mw_last_idx got=%0d exp=1020", idx_q[idx_q.size()-1]); end
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_load_kernel = 1'b0; i_num_cols = '0;
    bus.i_col_valid = 1'b0; bus.i_res_ready = 1'b0;
    kern_col = 24'h010101; img_col = 24'h020202;
    test_reset();
    test_kernel_frame();
    test_backpressure();
    test_err_then_short();
    test_toggle_valid();
    test_reset_mid();
    test_max_width();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_seq_ctrl.md
Name: conv_seq_ctrl

Overview:
- Sequencer placed in front of the 3x3 convolution datapath (Conv).
- Accepts a column stream from upstream over a valid/ready handshake and drives Conv's i_dato0..2, i_selecK_I and i_valid.
- Runs the optional kernel load (3 columns), then W image columns, then one zero flush column so the last window is latched.
- Flags each valid convolution result to downstream, with backpressure, and reports per-frame completion.

Parameters:
BIT_LEN, 8, pixel/coefficient width
M_LEN, 3, kernel side; columns per kernel load
CNT_LEN, 10, width of column count and result index

Ports:
CLK100MHZ  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_start  in  1  start a frame; sampled only in IDLE
i_load_kernel  in  1  sampled with i_start; 1 = load kernel before the image
i_num_cols  in  CNT_LEN  image width W in columns; sampled with i_start
i_col_data  in  3*BIT_LEN  column {row2,row1,row0}
i_col_valid  in  1  upstream column valid
o_col_ready  out  1  column accepted when i_col_valid & o_col_ready
o_dato0  out  BIT_LEN  to Conv i_dato0 (= i_col_data[BIT_LEN-1:0]; 0 in DRAIN)
o_dato1  out  BIT_LEN  to Conv i_dato1
o_dato2  out  BIT_LEN  to Conv i_dato2
o_selecK_I  out  1  to Conv; 0 in LOAD_K, 1 otherwise
o_conv_valid  out  1  to Conv i_valid; one pulse per push
i_res_ready  in  1  downstream accepts the result
o_res_valid  out  1  Conv o_data holds a valid window
o_res_idx  out  CNT_LEN  window index of the current result (0..W-3)
o_busy  out  1  state != IDLE
o_done  out  1  one-cycle pulse at frame end
o_err  out  1  one-cycle pulse on start with W<3

Behaviour:
- States: IDLE, LOAD_K, IMG, DRAIN, WAIT_OUT.
- Reset: state IDLE. o_res_valid, o_res_idx, o_done, o_err and all counters are 0. Combinational outputs take their IDLE values: o_col_ready=0, o_conv_valid=0, o_selecK_I=1, o_dato*=0, o_busy=0.
- Reset mid-frame aborts to IDLE next cycle. Conv shares the same reset.
- IDLE, i_start=1:
  - i_num_cols<3: o_err=1 for one cycle; stay in IDLE.
  - Otherwise latch W and go to LOAD_K if i_load_kernel=1, else to IMG. The kernel is then retained from the previous frame.
- i_start outside IDLE is ignored.
- o_dato* equal the i_col_data slices combinationally in LOAD_K and IMG; they are 0 in all other states.
- o_conv_valid = accepted push (LOAD_K/IMG), or the flush push in DRAIN.
- LOAD_K:
  - o_col_ready=1 and o_selecK_I=0.
  - Count 3 accepted columns; after the third, go to IMG.
  - o_res_valid is unaffected.
- IMG:
  - o_col_ready = !o_res_valid | i_res_ready (combinational path from i_res_ready).
  - Push counter p = 0..W-1 (accepted columns).
  - An accepted push with p>=3 sets o_res_valid=1 and o_res_idx=p-3 on the next edge. Conv then latches window p-3 on that same edge.
  - After push p=W-1, go to DRAIN.
- DRAIN:
  - When !o_res_valid | i_res_ready, issue one push: o_dato*=0, o_conv_valid=1, o_selecK_I=1.
  - That push sets o_res_valid=1 with o_res_idx=W-3, then go to WAIT_OUT.
- WAIT_OUT: when o_res_valid & i_res_ready, clear o_res_valid, pulse o_done for one cycle and go to IDLE.
- o_res_valid clears on i_res_ready unless a push in the same cycle re-sets it. In that case it stays 1 and o_res_idx advances (back-to-back throughput of 1 result/cycle).
- While o_res_valid=1 and i_res_ready=0, no push occurs. This protects Conv's o_data, which changes on every image push.
- Outputs per frame: exactly W-2 results; kernel loads never produce results.
- W = 2^CNT_LEN-1 must count correctly (no counter wrap).

Test Plan:
- Reset then i_start, i_load_kernel=1, W=5, upstream always valid, i_res_ready=1:
  - 3 pushes with o_selecK_I=0, then 5 with o_selecK_I=1, then 1 zero push.
  - o_res_idx 0,1,2 on cycles after pushes 4,5 and the drain push.
  - o_done pulses once; total of 9 o_conv_valid pulses.
- Kernel of all 0x01 and image columns all 0x02 through real Conv: each result equals the Conv output for sum 18. Exactly 3 results.
- i_res_ready held 0 for 4 cycles after idx 0 appears:
  - o_col_ready=0 and no o_conv_valid during the hold.
  - o_res_valid and o_res_idx stable; Conv o_data stable.
- i_start with W=2 -> o_err one cycle, o_busy stays 0, no pushes. Then i_start with i_load_kernel=0, W=3 -> no LOAD_K, 3 pushes + drain, one result idx 0.
- i_col_valid toggling every other cycle, W=6: 4 results, idx 0..3 in order, no duplicate or missed o_conv_valid.
- i_reset asserted during IMG at p=2 -> next cycle IDLE, all outputs 0. A new frame then runs normally; i_start during busy is ignored.
